// File: rtl/fp_pkg.sv
// Shared constants and enums for the float/integer conversion datapath.
// FP2INT_ROUND_NEAREST_EN widens the shift path to e==126 for round-to-nearest-even.
package fp_pkg;

    localparam int EXP_W         = 8;
    localparam int FRAC_W        = 23;
    localparam int MANT_W        = FRAC_W + 1;
    localparam int BIAS          = 127;
    localparam int EXP_INT_LIMIT = 158;

    localparam logic [31:0] INT_MAX    = 32'h7FFF_FFFF;
    localparam logic [31:0] INT_MIN    = 32'h8000_0000;
    // The one float at or above 2^31 that still fits: exactly -2^31.
    localparam logic [31:0] FP_INT_MIN = 32'hCF00_0000;

    // Exponent at which the mantissa already sits at the integer binary point.
    localparam logic [EXP_W-1:0] EXP_NO_SHIFT = EXP_W'(BIAS + FRAC_W);
    localparam logic [EXP_W-1:0] EXP_LIMIT    = EXP_W'(EXP_INT_LIMIT);
    localparam logic [EXP_W-1:0] EXP_ALL_ONES = '1;
`ifdef FP2INT_ROUND_NEAREST_EN
    localparam logic [EXP_W-1:0] EXP_MIN_SHIFT = EXP_W'(BIAS - 1);
`else
    localparam logic [EXP_W-1:0] EXP_MIN_SHIFT = EXP_W'(BIAS);
`endif

    typedef enum logic [2:0] {IDLE, CLASSIFY, SHIFT, SIGN, DONE} state_t;
    typedef enum logic [2:0] {ZERO, TINY, NORMAL, SAT, NAN} fp_class_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational operand classifier: case, shift direction and shift distance.
// Shared with the adder's special-case stage; honours FP2INT_ROUND_NEAREST_EN via fp_pkg.
module fp_classify
    import fp_pkg::*;
(
    input  logic [31:0] a,
    output fp_class_t   cls,
    output logic        shift_left,
    output logic [4:0]  shift_n
);

    logic [EXP_W-1:0]  e;
    logic [FRAC_W-1:0] f;

    assign e = a[30:23];
    assign f = a[22:0];

    // NOTE: every output gets a default first so no path through the
    // if-chain leaves a value unassigned and infers a latch.
    always_comb begin
        cls        = NORMAL;
        shift_left = 1'b0;
        shift_n    = '0;
        if (e == EXP_ALL_ONES) begin
            cls = (f != '0) ? NAN : SAT;
        end else if (e >= EXP_LIMIT) begin
            cls = SAT;
        end else if (e < EXP_MIN_SHIFT) begin
            cls = (e == '0 && f == '0) ? ZERO : TINY;
        end else if (e >= EXP_NO_SHIFT) begin
            shift_left = 1'b1;
            shift_n    = 5'(e - EXP_NO_SHIFT);
        end else begin
            shift_n    = 5'(EXP_NO_SHIFT - e);
        end
    end

endmodule

// File: rtl/fp2int.sv
// Multi-cycle IEEE 754 single to signed 32-bit integer converter, start/done level handshake.
// Truncates toward zero by default; FP2INT_ROUND_NEAREST_EN selects round-to-nearest-even.
module fp2int
    import fp_pkg::*;
#(
    parameter int SHIFT_STEP = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    output logic [31:0] result,
    output logic        done,
    output logic        invalid,
    output logic        inexact
);

    localparam logic [5:0] STEP = 6'(SHIFT_STEP);

    state_t      state, next_state;
    logic [31:0] op;
    logic [31:0] mag;
    logic        guard, sticky;
    logic [4:0]  n;
    logic        left;

    fp_class_t   cls;
    logic        cls_left;
    logic [4:0]  cls_n;

    fp_classify u_classify (
        .a          (op),
        .cls        (cls),
        .shift_left (cls_left),
        .shift_n    (cls_n)
    );

    // One shift step: distance min(n, SHIFT_STEP); bits leaving on the right feed guard/sticky.
    logic [5:0]  step;
    logic [4:0]  n_next;
    logic [63:0] ext;
    logic [31:0] mag_shifted;
    logic        guard_next, sticky_next;

    always_comb begin
        step        = ({1'b0, n} > STEP) ? STEP : {1'b0, n};
        n_next      = n - step[4:0];
        ext         = {mag, 32'b0} >> step;
        mag_shifted = left ? (mag << step) : ext[63:32];
        guard_next  = left ? guard  : ext[31];
        sticky_next = left ? sticky : (sticky | guard | (|ext[30:0]));
    end

    logic [31:0] mag_rnd;
    logic [31:0] signed_mag;

    always_comb begin
`ifdef FP2INT_ROUND_NEAREST_EN
        mag_rnd = mag + 32'(guard & (sticky | mag[0]));
`else
        mag_rnd = mag;
`endif
        signed_mag = op[31] ? (-mag_rnd) : mag_rnd;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (start) next_state = CLASSIFY;
            CLASSIFY: begin
                if (cls != NORMAL)      next_state = DONE;
                else if (cls_n != '0)   next_state = SHIFT;
                else                    next_state = SIGN;
            end
            SHIFT:    if (n_next == '0) next_state = SIGN;
            SIGN:     next_state = DONE;
            DONE:     if (!start) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // NOTE: datapath registers are few and cheap, so all of them are reset;
    // an aborted conversion then leaves no stale operand or shift state behind.
    always_ff @(posedge clk) begin
        if (reset) begin
            op      <= '0;
            mag     <= '0;
            guard   <= 1'b0;
            sticky  <= 1'b0;
            n       <= '0;
            left    <= 1'b0;
            result  <= '0;
            invalid <= 1'b0;
            inexact <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= (next_state == DONE);
            case (state)
                IDLE: if (start) op <= a;
                CLASSIFY: begin
                    case (cls)
                        NAN: begin
                            result  <= INT_MAX;
                            invalid <= 1'b1;
                            inexact <= 1'b0;
                        end
                        SAT: begin
                            if (op == FP_INT_MIN) begin
                                result  <= INT_MIN;
                                invalid <= 1'b0;
                            end else begin
                                result  <= op[31] ? INT_MIN : INT_MAX;
                                invalid <= 1'b1;
                            end
                            inexact <= 1'b0;
                        end
                        ZERO: begin
                            result  <= '0;
                            invalid <= 1'b0;
                            inexact <= 1'b0;
                        end
                        TINY: begin
                            result  <= '0;
                            invalid <= 1'b0;
                            inexact <= 1'b1;
                        end
                        default: begin
                            mag    <= 32'({1'b1, op[FRAC_W-1:0]});
                            guard  <= 1'b0;
                            sticky <= 1'b0;
                            n      <= cls_n;
                            left   <= cls_left;
                        end
                    endcase
                end
                SHIFT: begin
                    mag    <= mag_shifted;
                    guard  <= guard_next;
                    sticky <= sticky_next;
                    n      <= n_next;
                end
                SIGN: begin
                    result  <= signed_mag;
                    invalid <= 1'b0;
                    inexact <= guard | sticky;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp2int.sv
// Directed-vector bench for fp2int: table of conversions plus handshake, reset-abort
// and SHIFT_STEP=1 latency sequences.
module tb_fp2int;

    logic        clk = 1'b0;
    logic        reset;
    logic        start0, start1;
    logic [31:0] a0, a1;
    logic [31:0] result0, result1;
    logic        done0, done1, invalid0, invalid1, inexact0, inexact1;

    always #5 clk = ~clk;

    fp2int #(.SHIFT_STEP(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start0),
        .a       (a0),
        .result  (result0),
        .done    (done0),
        .invalid (invalid0),
        .inexact (inexact0)
    );

    fp2int #(.SHIFT_STEP(1)) dut_step1 (
        .clk     (clk),
        .reset   (reset),
        .start   (start1),
        .a       (a1),
        .result  (result1),
        .done    (done1),
        .invalid (invalid1),
        .inexact (inexact1)
    );

    int n_applied    = 0;
    int n_miscompare = 0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_applied++;
        if (actual !== expected) begin
            n_miscompare++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Launch a conversion, scramble the operand after capture, and count edges until done.
    task automatic convert(input bit sel, input logic [31:0] op, output int lat);
        @(negedge clk);
        if (sel) begin a1 = op; start1 = 1'b1; end
        else     begin a0 = op; start0 = 1'b1; end
        @(posedge clk);
        #1;
        if (sel) a1 = ~op;
        else     a0 = ~op;
        lat = 1;
        while (!(sel ? done1 : done0) && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic finish_handshake(input bit sel, input string name);
        @(negedge clk);
        if (sel) start1 = 1'b0;
        else     start0 = 1'b0;
        @(posedge clk);
        #1;
        check(name, 64'(sel ? done1 : done0), 64'd0);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] res;
        logic        inv;
        logic        inx;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int  lat;
        bit  seen_done;

        vecs.push_back('{32'h3F80_0000, 32'h0000_0001, 1'b0, 1'b0, 6});
        vecs.push_back('{32'hC049_0FDB, 32'hFFFF_FFFD, 1'b0, 1'b1, 6});
        vecs.push_back('{32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0, 1'b0, 4});
        vecs.push_back('{32'hCEFF_FFFF, 32'h8000_0080, 1'b0, 1'b0, 4});
        vecs.push_back('{32'h4B00_0000, 32'h0080_0000, 1'b0, 1'b0, 3});
        vecs.push_back('{32'h4F00_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 2});
        vecs.push_back('{32'hCF00_0000, 32'h8000_0000, 1'b0, 1'b0, 2});
        vecs.push_back('{32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 2});
        vecs.push_back('{32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0, 2});
        vecs.push_back('{32'h7F80_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 2});
        vecs.push_back('{32'h0000_0001, 32'h0000_0000, 1'b0, 1'b1, 2});
        vecs.push_back('{32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 2});
        vecs.push_back('{32'h4020_0000, 32'h0000_0002, 1'b0, 1'b1, 6});
`ifdef FP2INT_ROUND_NEAREST_EN
        vecs.push_back('{32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b1, 6});
        vecs.push_back('{32'h3FC0_0000, 32'h0000_0002, 1'b0, 1'b1, 6});
        vecs.push_back('{32'hBF40_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 6});
        vecs.push_back('{32'h3F7F_FFFF, 32'h0000_0001, 1'b0, 1'b1, 6});
`else
        vecs.push_back('{32'h3F00_0000, 32'h0000_0000, 1'b0, 1'b1, 2});
        vecs.push_back('{32'h3FC0_0000, 32'h0000_0001, 1'b0, 1'b1, 6});
        vecs.push_back('{32'hBF40_0000, 32'h0000_0000, 1'b0, 1'b1, 2});
        vecs.push_back('{32'h3F7F_FFFF, 32'h0000_0000, 1'b0, 1'b1, 2});
`endif

        reset  = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        a0     = '0;
        a1     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {result0, done0, invalid0, inexact0}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            convert(1'b0, vecs[i].a, lat);
            check($sformatf("v%0d_%08h_latency", i, vecs[i].a), 64'(lat), 64'(vecs[i].lat));
            check($sformatf("v%0d_%08h_result", i, vecs[i].a), 64'(result0), 64'(vecs[i].res));
            check($sformatf("v%0d_%08h_flags", i, vecs[i].a), {invalid0, inexact0}, {vecs[i].inv, vecs[i].inx});
            finish_handshake(1'b0, $sformatf("v%0d_done_drop", i));
        end

        // SHIFT_STEP=1: 1.0 needs 23 single-bit shift cycles.
        convert(1'b1, 32'h3F80_0000, lat);
        check("step1_latency", 64'(lat), 64'd26);
        check("step1_result", {result1, invalid1, inexact1}, {32'h0000_0001, 2'b00});
        finish_handshake(1'b1, "step1_done_drop");

        // Hold start in DONE: outputs must stay put, then drop on the release edge.
        convert(1'b0, 32'hC049_0FDB, lat);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("hold%0d", k), {result0, done0, inexact0}, {32'hFFFF_FFFD, 1'b1, 1'b1});
        end
        @(negedge clk);
        start0 = 1'b0;
        @(posedge clk);
        #1;
        check("release_done", 64'(done0), 64'd0);
        check("release_keeps_result", {result0, invalid0, inexact0}, {32'hFFFF_FFFD, 2'b01});

        // Reset during SHIFT aborts the conversion with no done pulse.
        @(negedge clk);
        a0     = 32'h3F80_0000;
        start0 = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_outputs", {result0, done0, invalid0, inexact0}, 64'd0);
        @(negedge clk);
        reset  = 1'b0;
        start0 = 1'b0;
        seen_done = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (done0) seen_done = 1'b1;
        end
        check("abort_no_done", 64'(seen_done), 64'd0);

        convert(1'b0, 32'h4EFF_FFFF, lat);
        check("post_abort_latency", 64'(lat), 64'd4);
        check("post_abort_result", {result0, invalid0, inexact0}, {32'h7FFF_FF80, 2'b00});
        finish_handshake(1'b0, "post_abort_done_drop");

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompare);
        $finish;
    end

endmodule
